// File: rtl/divide.sv
`default_nettype none
// ============================================================================
//  Module   : divide
//  Purpose  : Iterative radix-2 restoring divider. It divides a
//             MAC_MULT_WIDTH (2N) dividend by a MAC_MIN_WIDTH (N) divisor
//             and returns a 2N-bit quotient and an N-bit remainder. It
//             produces one quotient bit per cycle, MSB first. It holds one
//             operation at a time.
//  Ports    : clk, rst_n      - clock and synchronous active-low reset
//             in_valid/ready  - operand handshake (DIVIDEND, DIVISOR)
//             out_valid/ready - result handshake (QUOT, REM, DIV_BY_ZERO)
//  Options  : Defining MAC_DIV_SIGNED_EN makes the block treat its operands
//             as two's complement. The quotient truncates toward zero and
//             the remainder takes the sign of the dividend.
//  Revision : 1.0 - initial release
// ============================================================================
module divide #(
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAC_MULT_WIDTH-1:0] DIVIDEND,
    input  logic [MAC_MIN_WIDTH-1:0]  DIVISOR,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_MULT_WIDTH-1:0] QUOT,
    output logic [MAC_MIN_WIDTH-1:0]  REM,
    output logic                      DIV_BY_ZERO
);

    localparam int N  = MAC_MIN_WIDTH;
    localparam int M  = MAC_MULT_WIDTH;
    localparam int CW = $clog2(M) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;

    logic [M-1:0]  r_acc;    // dividend shifts out MSB-first, quotient shifts in
    logic [N-1:0]  r_dvs;
    logic [N-1:0]  r_prem;   // partial remainder, always < divisor
    logic [CW-1:0] r_cnt;
    logic [M-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_dbz;

    logic          w_accept;
    logic          w_dvs_zero;
    logic          w_last;
    logic [M-1:0]  w_dvd_in;
    logic [N-1:0]  w_dvs_in;
    logic [N:0]    w_shift;
    logic          w_ge;
    logic [N-1:0]  w_prem_next;
    logic [M-1:0]  w_acc_next;
    logic [M-1:0]  w_quot_fin;
    logic [N-1:0]  w_rem_fin;

    assign w_accept   = in_valid && in_ready;
    assign w_dvs_zero = (DIVISOR == '0);
    assign w_last     = (r_cnt == CW'(M - 1));

    // One restoring step. The shifted remainder is below 2*divisor, so it
    // fits N+1 bits. The kept result is below the divisor, so it fits N bits.
    assign w_shift     = {r_prem, r_acc[M-1]};
    assign w_ge        = (w_shift >= {1'b0, r_dvs});
    assign w_prem_next = w_ge ? N'(w_shift - {1'b0, r_dvs}) : w_shift[N-1:0];
    assign w_acc_next  = {r_acc[M-2:0], w_ge};

`ifdef MAC_DIV_SIGNED_EN
    logic r_qneg;
    logic r_rneg;

    // The core runs on magnitudes. The most negative value keeps its
    // bit pattern, which is its correct unsigned magnitude.
    assign w_dvd_in   = DIVIDEND[M-1] ? -DIVIDEND : DIVIDEND;
    assign w_dvs_in   = DIVISOR[N-1]  ? -DIVISOR  : DIVISOR;
    assign w_quot_fin = r_qneg ? -w_acc_next  : w_acc_next;
    assign w_rem_fin  = r_rneg ? -w_prem_next : w_prem_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (w_accept) begin
            r_qneg <= DIVIDEND[M-1] ^ DIVISOR[N-1];
            r_rneg <= DIVIDEND[M-1];
        end
    end
`else
    assign w_dvd_in   = DIVIDEND;
    assign w_dvs_in   = DIVISOR;
    assign w_quot_fin = w_acc_next;
    assign w_rem_fin  = w_prem_next;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)  w_next_state = w_dvs_zero ? c_DONE : c_CALC;
            c_CALC:  if (w_last)    w_next_state = c_DONE;
            c_DONE:  if (out_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_dvs  <= '0;
            r_prem <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_acc  <= w_dvd_in;
                        r_dvs  <= w_dvs_in;
                        r_prem <= '0;
                        r_cnt  <= '0;
                        if (w_dvs_zero) begin
                            // Raw low dividend bits, independent of signed mode
                            r_quot <= '1;
                            r_rem  <= DIVIDEND[N-1:0];
                            r_dbz  <= 1'b1;
                        end else begin
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                c_CALC: begin
                    r_acc  <= w_acc_next;
                    r_prem <= w_prem_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quot <= w_quot_fin;
                        r_rem  <= w_rem_fin;
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign QUOT        = r_quot;
    assign REM         = r_rem;
    assign DIV_BY_ZERO = r_dbz;

endmodule
`default_nettype wire

// File: doc/divide.md
Name: divide

Overview:
- Iterative radix-2 restoring divider; inverse of the multiply block: takes a MAC_MULT_WIDTH product-width dividend and a MAC_MIN_WIDTH divisor, returns quotient and remainder.
- Used by the MAC datapath for normalization and averaging.
- Valid/ready handshakes on input and output; one result in flight at a time.

Parameters:
- MAC_MIN_WIDTH, 8, divisor and remainder width (N).
- MAC_MULT_WIDTH, 2*MAC_MIN_WIDTH, dividend and quotient width (2N).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- DIVIDEND  input  MAC_MULT_WIDTH  dividend.
- DIVISOR  input  MAC_MIN_WIDTH  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- QUOT  output  MAC_MULT_WIDTH  quotient.
- REM  output  MAC_MIN_WIDTH  remainder.
- DIV_BY_ZERO  output  1  result came from DIVISOR==0.

Behaviour:
- Reset (rst_n==0 at a clk edge): state=IDLE; in_ready=1, out_valid=0, QUOT=0, REM=0, DIV_BY_ZERO=0. Reset mid-CALC or mid-DONE aborts the operation and discards the result.
- FSM: IDLE -> CALC -> DONE -> IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready (edge E0), latch operands.
  - Clear the N+1-bit partial remainder and the iteration counter.
  - Go to CALC, or to DONE directly if DIVISOR==0.
- CALC: one quotient bit per cycle, MSB first.
  - Shift the partial remainder left and bring in the next dividend bit.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set the quotient bit to 0.
  - Exactly 2N iterations, on edges E1..E2N. State is DONE after E2N.
  - Latency: acceptance to out_valid = 2N cycles (16 for N=8).
- DONE:
  - QUOT, REM and DIV_BY_ZERO are stable and held for as long as out_valid&&!out_ready.
  - On out_ready, go to IDLE on that edge; in_ready is 1 the following cycle.
  - No same-cycle accept while in DONE.
- Divide by zero:
  - QUOT = all ones, REM = DIVIDEND[N-1:0], DIV_BY_ZERO=1.
  - out_valid is high 1 cycle after acceptance.
  - DIV_BY_ZERO=0 for every other result.
- Widths and invariants:
  - REM < DIVISOR always; REM fits N bits.
  - QUOT is full 2N bits, so unsigned overflow is impossible.
  - QUOT*DIVISOR + REM == DIVIDEND exactly.
- Inputs are ignored while in_ready==0; DIVIDEND/DIVISOR changes during CALC have no effect.
- out_ready is ignored while out_valid==0.

Optional Feature:
- Macro: MAC_DIV_SIGNED_EN.
- Defined:
  - DIVIDEND and DIVISOR are two's complement.
  - Magnitudes are taken at acceptance; the unsigned core runs unchanged.
  - Signs are applied on entry to DONE: quotient truncates toward zero, remainder takes the dividend's sign, |REM| < |DIVISOR|.
  - -2^(2N-1) / -1 wraps to -2^(2N-1) with no flag.
  - Divide by zero still gives QUOT=all ones (-1), REM=DIVIDEND[N-1:0], DIV_BY_ZERO=1.
  - Latency is unchanged.
- Undefined: unsigned only, no sign logic synthesized.

Test Plan:
- N=8, unsigned: DIVIDEND=1000, DIVISOR=7 -> after 16 cycles out_valid=1, QUOT=142, REM=6, DIV_BY_ZERO=0.
- DIVIDEND=0xFFFF, DIVISOR=0xFF -> QUOT=257, REM=0. DIVIDEND=0xFFFF, DIVISOR=1 -> QUOT=0xFFFF, REM=0.
- DIVIDEND=0x1234, DIVISOR=0 -> out_valid 1 cycle after accept, QUOT=0xFFFF, REM=0x34, DIV_BY_ZERO=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout.
  - Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 the next cycle.
  - A new operand pair is accepted back-to-back.
- Reset mid-op: rst_n=0 at cycle 5 of CALC -> next cycle in_ready=1, out_valid=0, QUOT=0, REM=0. A following 100/3 gives QUOT=33, REM=1.
- With MAC_DIV_SIGNED_EN, N=8:
  - -100/7 -> QUOT=-14 (0xFFF2), REM=-2 (0xFE).
  - 100/-7 -> QUOT=-14, REM=2.
  - -32768/-1 -> QUOT=0x8000, REM=0.
